sipo_collector: RTL and testbench
=================================

SIPO_COLLECTOR -- requirements
Module: sipo_collector

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, default 4, word length in bits; legal range 2..16.
REQ-002 Port clk SHALL be: clk  input  1  rising-edge clock.
REQ-003 Port rst SHALL be: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port enable SHALL be: enable  input  1  din is a valid serial bit this cycle.
REQ-005 Port din SHALL be: din  input  1  serial data, LSB first.
REQ-006 Port ready SHALL be: ready  input  1  consumer accepts data when valid is high.
REQ-007 Port clr_ovr SHALL be: clr_ovr  input  1  synchronous clear of overrun.
REQ-008 Port data SHALL be: data  output  WIDTH  last completed word (holding register).
REQ-009 Port valid SHALL be: valid  output  1  data holds an unconsumed word.
REQ-010 Port busy SHALL be: busy  output  1  partial word in progress (bit count nonzero).
REQ-011 Port overrun SHALL be: overrun  output  1  sticky flag, a completed word was dropped.
REQ-012 All outputs SHALL be registered.

Function
REQ-013 The block SHALL consume the serial stream produced by an enable-gated LSB-first parallel-to-serial shifter, one bit per clk with enable high.
REQ-014 The FSM SHALL have states IDLE (count 0) and COLLECT (1..WIDTH-1 bits held).
REQ-015 Transitions SHALL be: IDLE->COLLECT on enable; COLLECT->COLLECT on enable while count < WIDTH-1; COLLECT->IDLE on enable with count = WIDTH-1; no transition without enable.
REQ-016 With enable low, shift register, count and state SHALL hold unchanged (stall, no timeout).
REQ-017 Each accepted bit SHALL enter the shift register MSB and shift it right, so the first received bit lands in bit 0 at completion.
REQ-018 The bit counter SHALL be clog2(WIDTH) bits wide and wrap to 0 at the completing bit.
REQ-019 On the completing bit, the assembled word including that bit SHALL be transferred to data on the same clk edge; latency is 0 cycles from the last bit's edge to valid = 1.
REQ-020 The handshake SHALL transfer a word when valid && ready; valid SHALL drop the following cycle unless a new word completes on that edge.
REQ-021 data SHALL remain stable while valid is high and no transfer occurs.
REQ-022 If a completion coincides with valid && ready, the new word SHALL load, valid SHALL stay 1, and overrun SHALL be unchanged.
REQ-023 If a completion occurs while valid && !ready, the new word SHALL be discarded, data SHALL keep the old word, and overrun SHALL be set.
REQ-024 overrun SHALL clear only on clr_ovr or rst; if clr_ovr coincides with a new overrun event, set SHALL take priority.
REQ-025 busy SHALL be 1 exactly when state is COLLECT.

Reset
REQ-026 On rst, state SHALL be IDLE, count 0, and shift register 0, with data = 0, valid = 0, busy = 0 and overrun = 0, taking effect immediately without waiting for clk.
REQ-027 Reset mid-word SHALL discard the partial word; the next enable bit after release SHALL be treated as bit 0.

Verification
REQ-028 A bench SHALL cover: WIDTH = 4, enable high, din 1,0,1,1 on consecutive cycles, ready = 1 -> data = 4'hD, valid high for exactly 1 cycle, busy high for 3 cycles.
REQ-029 A bench SHALL cover: same bits with enable low for 2 cycles between bit1 and bit2 -> data = 4'hD, and busy stays 1 during the stall.
REQ-030 A bench SHALL cover: ready = 0, words 4'hD then 4'h6 (0,1,1,0) -> data stays 4'hD, valid = 1, and overrun = 1; then clr_ovr -> overrun = 0.
REQ-031 A bench SHALL cover: ready = 0 through word 4'h3, then ready = 1 on the edge completing word 4'hA -> data = 4'hA, valid stays 1, and overrun = 0.
REQ-032 A bench SHALL cover: rst pulsed after 2 bits, then 4 bits 0,0,0,1 -> data = 4'h8, with no contribution from the pre-reset bits.
REQ-033 A bench SHALL cover: WIDTH = 8, 16 bits forming 8'hA5 then 8'h3C, ready = 1 -> two valid pulses carrying those values, and count wraps correctly.

Source files
------------

// File: rtl/sipo_collector.sv
// Serial-in, parallel-out collector: assembles LSB-first words from an enable-gated
// bit stream and presents them through a valid/ready holding register with a sticky overrun flag.
module sipo_collector #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             din,
  input  logic             ready,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             busy,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;
  logic             complete_s;

  // Bit collection: new bit enters at the MSB so the first bit ends in bit 0.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    complete_s = 1'b0;
    if (enable) begin
      shift_d = {din, {(WIDTH-1){1'b0}}} | (shift_q >> 1'b1);
      if (cnt_q == LAST) begin
        cnt_d      = {CW{1'b0}};
        state_d    = IDLE;
        complete_s = 1'b1;
      end else begin
        cnt_d   = cnt_q + CW'(1'b1);
        state_d = COLLECT;
      end
    end else begin
      state_d = state_q;
    end
    case (state_d)
      IDLE:    busy_d = 1'b0;
      COLLECT: busy_d = 1'b1;
      default: busy_d = 1'b0;
    endcase
  end

  // Holding register handshake; an unconsumed word blocks new ones, which are dropped.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (complete_s) begin
      if (!valid_q || ready) begin
        data_d  = shift_d;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    // A new drop outranks a simultaneous clear.
    if (clr_ovr && !(complete_s && valid_q && !ready)) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_d;
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= {CW{1'b0}};
      shift_q   <= {WIDTH{1'b0}};
      data_q    <= {WIDTH{1'b0}};
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign data    = data_q;
  assign valid   = valid_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_sipo_collector.sv
// Bench for sipo_collector: WIDTH=4 and WIDTH=8 instances share one input stream and are
// checked every cycle against a word-level reference model plus directed constant checks.
module tb_sipo_collector;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       din;
  logic       ready;
  logic       clr_ovr;
  logic [3:0] data4;
  logic       valid4, busy4, overrun4;
  logic [7:0] data8;
  logic       valid8, busy8, overrun8;

  int n_cmp = 0;
  int n_bad = 0;
  int v_cnt = 0;
  int b_cnt = 0;
  int v8_cnt = 0;

  // reference model state, index 0 -> WIDTH 4, index 1 -> WIDTH 8
  int m_cnt[2];
  int m_acc[2];
  int m_data[2];
  bit m_valid[2];
  bit m_ovr[2];

  sipo_collector #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .enable(enable), .din(din), .ready(ready), .clr_ovr(clr_ovr),
    .data(data4), .valid(valid4), .busy(busy4), .overrun(overrun4)
  );

  sipo_collector #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .enable(enable), .din(din), .ready(ready), .clr_ovr(clr_ovr),
    .data(data8), .valid(valid8), .busy(busy8), .overrun(overrun8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int wd(input int k);
    return (k == 0) ? 4 : 8;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_acc[k] = 0; m_data[k] = 0; m_valid[k] = 1'b0; m_ovr[k] = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_data4"},  {12'd0, data4},    16'(m_data[0]));
    chk({tag, "_valid4"}, {15'd0, valid4},   {15'd0, m_valid[0]});
    chk({tag, "_busy4"},  {15'd0, busy4},    {15'd0, m_cnt[0] != 0});
    chk({tag, "_ovr4"},   {15'd0, overrun4}, {15'd0, m_ovr[0]});
    chk({tag, "_data8"},  {8'd0, data8},     16'(m_data[1]));
    chk({tag, "_valid8"}, {15'd0, valid8},   {15'd0, m_valid[1]});
    chk({tag, "_busy8"},  {15'd0, busy8},    {15'd0, m_cnt[1] != 0});
    chk({tag, "_ovr8"},   {15'd0, overrun8}, {15'd0, m_ovr[1]});
  endtask

  // asynchronous reset: outputs must clear before any clock edge
  task automatic do_reset();
    #2;
    rst = 1'b1;
    enable = 1'b0; din = 1'b0; ready = 1'b0; clr_ovr = 1'b0;
    #1;
    model_reset();
    check_all("rst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(input bit en, input bit d, input bit rdy, input bit clr);
    enable = en; din = d; ready = rdy; clr_ovr = clr;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      bit done;
      bit ovr_ev;
      int word;
      done = 1'b0; ovr_ev = 1'b0; word = 0;
      if (en) begin
        m_acc[k] += int'(d) << m_cnt[k];
        m_cnt[k]++;
        if (m_cnt[k] == wd(k)) begin
          done = 1'b1; word = m_acc[k]; m_cnt[k] = 0; m_acc[k] = 0;
        end
      end
      if (done) begin
        if (!m_valid[k] || rdy) begin
          m_data[k] = word; m_valid[k] = 1'b1;
        end else begin
          ovr_ev = 1'b1;
        end
      end else if (m_valid[k] && rdy) begin
        m_valid[k] = 1'b0;
      end
      if (ovr_ev) m_ovr[k] = 1'b1;
      else if (clr) m_ovr[k] = 1'b0;
    end
    #1;
    check_all("step");
    if (valid4) v_cnt++;
    if (busy4) b_cnt++;
    if (valid8) v8_cnt++;
  endtask

  task automatic send4(input logic [3:0] w, input bit rdy);
    for (int i = 0; i < 4; i++) step(1'b1, w[i], rdy, 1'b0);
  endtask

  initial begin
    logic [7:0] w8;
    rst = 1'b1; enable = 1'b0; din = 1'b0; ready = 1'b0; clr_ovr = 1'b0;
    model_reset();
    do_reset();

    // single word, consumer always ready
    v_cnt = 0; b_cnt = 0;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("s1_data", {12'd0, data4}, 16'h000D);
    chk("s1_valid", {15'd0, valid4}, 16'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("s1_valid_cycles", 16'(v_cnt), 16'd1);
    chk("s1_busy_cycles", 16'(b_cnt), 16'd3);

    // stall between bit1 and bit2
    do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("s2_busy_stall_a", {15'd0, busy4}, 16'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("s2_busy_stall_b", {15'd0, busy4}, 16'd1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("s2_data", {12'd0, data4}, 16'h000D);

    // overrun with stalled consumer, then clear
    do_reset();
    send4(4'hD, 1'b0);
    send4(4'h6, 1'b0);
    chk("s3_data", {12'd0, data4}, 16'h000D);
    chk("s3_valid", {15'd0, valid4}, 16'd1);
    chk("s3_ovr", {15'd0, overrun4}, 16'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("s3_ovr_clr", {15'd0, overrun4}, 16'd0);

    // completion coinciding with a transfer
    do_reset();
    send4(4'h3, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("s4_data", {12'd0, data4}, 16'h000A);
    chk("s4_valid", {15'd0, valid4}, 16'd1);
    chk("s4_ovr", {15'd0, overrun4}, 16'd0);

    // reset mid-word discards the partial word
    do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    do_reset();
    send4(4'h8, 1'b1);
    chk("s5_data", {12'd0, data4}, 16'h0008);

    // WIDTH=8, two back-to-back words
    do_reset();
    v8_cnt = 0;
    w8 = 8'hA5;
    for (int i = 0; i < 8; i++) step(1'b1, w8[i], 1'b1, 1'b0);
    chk("s6_data_a5", {8'd0, data8}, 16'h00A5);
    chk("s6_busy_wrap", {15'd0, busy8}, 16'd0);
    w8 = 8'h3C;
    for (int i = 0; i < 8; i++) step(1'b1, w8[i], 1'b1, 1'b0);
    chk("s6_data_3c", {8'd0, data8}, 16'h003C);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("s6_valid_pulses", 16'(v8_cnt), 16'd2);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i % 97 == 50) do_reset();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
